top_controller: RTL and testbench

- Top-level image-centroid engine.
- Receives a raster-scanned 8-bit grayscale image over UART (8N1) and accumulates intensity-weighted moments on the fly, with no frame buffer.
- At end of frame, computes the integer centroid (X, Y) with a sequential divider and transmits it back over UART as two bytes.
- Sits directly on the board UART pins.

---
 rtl/top_controller_pkg.sv | 46 ++++
 rtl/top_controller_uart_rx.sv | 96 +++++++++
 rtl/top_controller_uart_tx.sv | 82 ++++++++
 rtl/top_controller.sv | 204 ++++++++++++++++++++
 tb/tb_top_controller.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/top_controller_pkg.sv
// Shared constants, types and FSM encodings for the UART image-centroid engine.
package top_controller_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int IMG_W_DEFAULT        = 50;
  localparam int IMG_H_DEFAULT        = 50;

  localparam int S0_W = 20;
  localparam int M_W  = 26;

  localparam logic [7:0] EMPTY_CODE = 8'hFF;

  typedef enum logic [2:0] {
    COLLECT,
    DIVIDE_X,
    DIVIDE_Y,
    SEND_X,
    SEND_Y
  } frame_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef struct packed {
    logic [S0_W-1:0] s0;
    logic [M_W-1:0]  sx;
    logic [M_W-1:0]  sy;
  } moments_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/top_controller_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampler, glitch and framing rejection.
module uart_rx
  import top_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          rxd_meta;
  logic          rxd_sync;
  logic          rxd_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_valid <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            cnt_reg   <= '0;
            state_reg <= RX_START;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            if (bit_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg <= '0;
            if (rxd_sync) begin
              rx_data   <= shift_reg;
              rx_valid  <= 1'b1;
              state_reg <= RX_IDLE;
            end else begin
              state_reg <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_sync) begin
            state_reg <= RX_IDLE;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/top_controller_uart_tx.sv
// 8N1 UART transmitter: accepts a byte on start while idle, busy until the stop bit ends.
module uart_tx
  import top_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;

  assign txd     = txd_reg;
  assign tx_busy = (state_reg != TX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          if (tx_start) begin
            shift_reg <= tx_data;
            txd_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
            state_reg <= TX_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg <= '0;
            if (bit_reg == 3'd7) begin
              txd_reg   <= 1'b1;
              state_reg <= TX_STOP;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              txd_reg   <= shift_reg[1];
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            state_reg <= TX_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/top_controller.sv
// Image-centroid engine: streams pixels in over UART, accumulates moments,
// divides at end of frame and sends the (X, Y) centroid back as two bytes.
module top_controller
  import top_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int IMG_W        = IMG_W_DEFAULT,
  parameter int IMG_H        = IMG_H_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int XW = cnt_width(IMG_W);
  localparam int YW = cnt_width(IMG_H);
  localparam int PW = cnt_width(NUM_PIX);
  localparam int DW = cnt_width(M_W);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIX - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(M_W - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_start_reg;
  logic [7:0] tx_data_reg;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start_reg),
    .tx_data  (tx_data_reg),
    .tx_busy  (tx_busy),
    .txd      (txd)
  );

  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [PW-1:0]   pix_cnt_reg;
  logic [S0_W-1:0] s0_reg;
  logic [M_W-1:0]  sx_reg;
  logic [M_W-1:0]  sy_reg;
  logic [S0_W-1:0] s0_sum;
  logic [M_W-1:0]  sx_sum;
  logic [M_W-1:0]  sy_sum;
  logic            frame_done;

  assign s0_sum     = s0_reg + S0_W'(rx_data);
  assign sx_sum     = sx_reg + M_W'(x_reg) * M_W'(rx_data);
  assign sy_sum     = sy_reg + M_W'(y_reg) * M_W'(rx_data);
  assign frame_done = rx_valid && (pix_cnt_reg == PIX_LAST);

  // Moment accumulation runs independently of the divide/send FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg       <= '0;
      y_reg       <= '0;
      pix_cnt_reg <= '0;
      s0_reg      <= '0;
      sx_reg      <= '0;
      sy_reg      <= '0;
    end else if (rx_valid) begin
      if (frame_done) begin
        x_reg       <= '0;
        y_reg       <= '0;
        pix_cnt_reg <= '0;
        s0_reg      <= '0;
        sx_reg      <= '0;
        sy_reg      <= '0;
      end else begin
        s0_reg      <= s0_sum;
        sx_reg      <= sx_sum;
        sy_reg      <= sy_sum;
        pix_cnt_reg <= pix_cnt_reg + PW'(1);
        if (x_reg == X_LAST) begin
          x_reg <= '0;
          y_reg <= y_reg + YW'(1);
        end else begin
          x_reg <= x_reg + XW'(1);
        end
      end
    end
  end

  frame_state_t    state_reg;
  moments_t        pend_reg;
  logic            pend_valid_reg;
  logic [S0_W-1:0] den_reg;
  logic [M_W-1:0]  sy_hold_reg;
  logic [M_W-1:0]  quo_reg;
  logic [S0_W-1:0] rem_reg;
  logic [DW-1:0]   step_reg;
  logic [7:0]      res_x_reg;
  logic [7:0]      res_y_reg;

  // Restoring division: quo_reg starts as the dividend and fills with quotient bits.
  logic [S0_W:0]   div_shift;
  logic            div_ge;
  logic [S0_W-1:0] rem_next;
  logic [M_W-1:0]  quo_next;
  logic            div_last;

  assign div_shift = {rem_reg, quo_reg[M_W-1]};
  assign div_ge    = (div_shift >= {1'b0, den_reg});
  assign rem_next  = div_ge ? S0_W'(div_shift - {1'b0, den_reg}) : div_shift[S0_W-1:0];
  assign quo_next  = {quo_reg[M_W-2:0], div_ge};
  assign div_last  = (step_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= COLLECT;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      den_reg        <= '0;
      sy_hold_reg    <= '0;
      quo_reg        <= '0;
      rem_reg        <= '0;
      step_reg       <= '0;
      res_x_reg      <= '0;
      res_y_reg      <= '0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      // Single result slot: a newer completed frame always overwrites it.
      if (frame_done) begin
        pend_reg.s0    <= s0_sum;
        pend_reg.sx    <= sx_sum;
        pend_reg.sy    <= sy_sum;
        pend_valid_reg <= 1'b1;
      end
      case (state_reg)
        COLLECT: begin
          if (pend_valid_reg) begin
            if (!frame_done) begin
              pend_valid_reg <= 1'b0;
            end
            den_reg     <= pend_reg.s0;
            sy_hold_reg <= pend_reg.sy;
            quo_reg     <= pend_reg.sx;
            rem_reg     <= '0;
            step_reg    <= '0;
            if (pend_reg.s0 == '0) begin
              res_x_reg <= EMPTY_CODE;
              res_y_reg <= EMPTY_CODE;
              state_reg <= SEND_X;
            end else begin
              state_reg <= DIVIDE_X;
            end
          end
        end
        DIVIDE_X: begin
          rem_reg  <= rem_next;
          quo_reg  <= quo_next;
          step_reg <= step_reg + DW'(1);
          if (div_last) begin
            res_x_reg <= quo_next[7:0];
            quo_reg   <= sy_hold_reg;
            rem_reg   <= '0;
            step_reg  <= '0;
            state_reg <= DIVIDE_Y;
          end
        end
        DIVIDE_Y: begin
          rem_reg  <= rem_next;
          quo_reg  <= quo_next;
          step_reg <= step_reg + DW'(1);
          if (div_last) begin
            res_y_reg <= quo_next[7:0];
            state_reg <= SEND_X;
          end
        end
        SEND_X: begin
          // tx_busy lags a start pulse by one cycle, so the pulse itself also blocks.
          if (!tx_busy && !tx_start_reg) begin
            tx_data_reg  <= res_x_reg;
            tx_start_reg <= 1'b1;
            state_reg    <= SEND_Y;
          end
        end
        SEND_Y: begin
          if (!tx_busy && !tx_start_reg) begin
            tx_data_reg  <= res_y_reg;
            tx_start_reg <= 1'b1;
            state_reg    <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_top_controller.sv
// Self-checking bench for top_controller on a reduced 8x6 image with a fast baud rate;
// expected centroids come from a plain-arithmetic model over the pixel array.
module tb_top_controller;

  localparam int CPB = 8;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int NP  = W * H;

  logic clk = 1'b0;
  logic rst;
  logic rxd = 1'b1;
  logic txd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] txq[$];
  logic [7:0] pix [NP];

  always #5 clk = ~clk;

  top_controller #(
    .CLKS_PER_BIT (CPB),
    .IMG_W        (W),
    .IMG_H        (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .txd (txd)
  );

  // Decode every byte the DUT transmits.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        failures++;
        $display("FAIL tx_stop_bit got=%b want=1", txd);
      end
      $display("tx byte 0x%02h", b);
      txq.push_back(b);
    end
  end

  function automatic logic [15:0] model_centroid();
    longint s0 = 0;
    longint sx = 0;
    longint sy = 0;
    for (int i = 0; i < NP; i++) begin
      s0 += pix[i];
      sx += longint'(i % W) * pix[i];
      sy += longint'(i / W) * pix[i];
    end
    if (s0 == 0) return 16'hFFFF;
    return {8'(sx / s0), 8'(sy / s0)};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pixels(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pix[i], 1'b1);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (txq.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        failures++;
        $display("FAIL reset_txd cycle=%0d got=%b want=1", i, txd);
      end
    end
    rst = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      failures++;
      $display("FAIL reset_idle_output got=%0d bytes want=0", txq.size());
    end
    $display("reset: txd idle checked, no output after release");
  endtask

  task automatic test_zero_frame();
    bit ok;
    logic [7:0] bx, by;
    foreach (pix[i]) pix[i] = 8'h00;
    send_pixels(0, NP - 1);
    wait_bytes(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL zero_timeout got=%0d bytes want=2", txq.size());
    end else begin
      bx = txq.pop_front();
      by = txq.pop_front();
      checks++;
      if (bx !== 8'hFF) begin failures++; $display("FAIL zero_x got=%02h want=ff", bx); end
      checks++;
      if (by !== 8'hFF) begin failures++; $display("FAIL zero_y got=%02h want=ff", by); end
      $display("zero frame: got (%02h,%02h)", bx, by);
    end
  endtask

  task automatic test_single_pixel();
    bit ok;
    int lat = 0;
    logic [7:0] bx, by;
    foreach (pix[i]) pix[i] = 8'h00;
    pix[3 * W + 5] = 8'h80;
    send_pixels(0, NP - 1);
    while (txd === 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat > 60) begin
      failures++;
      $display("FAIL single_latency got=%0d cycles want<=60", lat);
    end
    wait_bytes(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_timeout got=%0d bytes want=2", txq.size());
    end else begin
      bx = txq.pop_front();
      by = txq.pop_front();
      checks++;
      if (bx !== 8'd5) begin failures++; $display("FAIL single_x got=%02h want=05", bx); end
      checks++;
      if (by !== 8'd3) begin failures++; $display("FAIL single_y got=%02h want=03", by); end
      $display("single pixel: got (%02h,%02h) latency=%0d", bx, by, lat);
    end
  endtask

  task automatic test_uniform();
    bit ok;
    logic [7:0] bx, by;
    foreach (pix[i]) pix[i] = 8'h01;
    send_pixels(0, NP - 1);
    wait_bytes(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL uniform_timeout got=%0d bytes want=2", txq.size());
    end else begin
      bx = txq.pop_front();
      by = txq.pop_front();
      checks++;
      if (bx !== 8'd3) begin failures++; $display("FAIL uniform_x got=%02h want=03", bx); end
      checks++;
      if (by !== 8'd2) begin failures++; $display("FAIL uniform_y got=%02h want=02", by); end
      $display("uniform frame: got (%02h,%02h)", bx, by);
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [7:0] bx, by;
    logic [15:0] exp_c;
    for (int f = 0; f < 2; f++) begin
      foreach (pix[i]) pix[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      pix[$urandom_range(0, NP - 1)] = 8'($urandom_range(1, 255));
      exp_c = model_centroid();
      send_pixels(0, NP - 1);
      wait_bytes(2, 600, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL random_timeout frame=%0d got=%0d bytes want=2", f, txq.size());
      end else begin
        bx = txq.pop_front();
        by = txq.pop_front();
        checks++;
        if (bx !== exp_c[15:8]) begin failures++; $display("FAIL random_x frame=%0d got=%02h want=%02h", f, bx, exp_c[15:8]); end
        checks++;
        if (by !== exp_c[7:0]) begin failures++; $display("FAIL random_y frame=%0d got=%02h want=%02h", f, by, exp_c[7:0]); end
        $display("random frame %0d: got (%02h,%02h) want (%02h,%02h)", f, bx, by, exp_c[15:8], exp_c[7:0]);
      end
    end
  endtask

  task automatic test_framing_error();
    bit ok;
    logic [7:0] bx, by;
    logic [15:0] exp_c;
    foreach (pix[i]) pix[i] = 8'($urandom_range(0, 255));
    exp_c = model_centroid();
    send_pixels(0, 19);
    send_byte(8'h05, 1'b0);
    send_pixels(20, NP - 2);
    repeat (300) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      failures++;
      $display("FAIL framing_early_result got=%0d bytes want=0", txq.size());
    end
    send_pixels(NP - 1, NP - 1);
    wait_bytes(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL framing_timeout got=%0d bytes want=2", txq.size());
    end else begin
      bx = txq.pop_front();
      by = txq.pop_front();
      checks++;
      if (bx !== exp_c[15:8]) begin failures++; $display("FAIL framing_x got=%02h want=%02h", bx, exp_c[15:8]); end
      checks++;
      if (by !== exp_c[7:0]) begin failures++; $display("FAIL framing_y got=%02h want=%02h", by, exp_c[7:0]); end
      $display("framing error frame: got (%02h,%02h) want (%02h,%02h)", bx, by, exp_c[15:8], exp_c[7:0]);
    end
    txq.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] bx, by;
    foreach (pix[i]) pix[i] = 8'($urandom_range(1, 255));
    send_pixels(0, 19);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    foreach (pix[i]) pix[i] = 8'h00;
    pix[3 * W + 5] = 8'h80;
    send_pixels(0, NP - 1);
    wait_bytes(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_timeout got=%0d bytes want=2", txq.size());
    end else begin
      bx = txq.pop_front();
      by = txq.pop_front();
      checks++;
      if (bx !== 8'd5) begin failures++; $display("FAIL rstmid_x got=%02h want=05", bx); end
      checks++;
      if (by !== 8'd3) begin failures++; $display("FAIL rstmid_y got=%02h want=03", by); end
      $display("reset mid-frame: got (%02h,%02h)", bx, by);
    end
    repeat (400) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      failures++;
      $display("FAIL rstmid_extra got=%0d bytes want=0", txq.size());
    end
    txq.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] bx, by;
    logic [15:0] exp_c[2];
    for (int f = 0; f < 2; f++) begin
      foreach (pix[i]) pix[i] = 8'($urandom_range(0, 255));
      exp_c[f] = model_centroid();
      send_pixels(0, NP - 1);
    end
    wait_bytes(4, 800, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d bytes want=4", txq.size());
    end else begin
      for (int f = 0; f < 2; f++) begin
        bx = txq.pop_front();
        by = txq.pop_front();
        checks++;
        if (bx !== exp_c[f][15:8]) begin failures++; $display("FAIL b2b_x frame=%0d got=%02h want=%02h", f, bx, exp_c[f][15:8]); end
        checks++;
        if (by !== exp_c[f][7:0]) begin failures++; $display("FAIL b2b_y frame=%0d got=%02h want=%02h", f, by, exp_c[f][7:0]); end
        $display("back-to-back frame %0d: got (%02h,%02h) want (%02h,%02h)", f, bx, by, exp_c[f][15:8], exp_c[f][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_single_pixel();
    test_uniform();
    test_random_frames();
    test_framing_error();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
